// File: rtl/dmux_bank8_pkg.sv
// dmux_bank8_pkg
//   Shared constants and helpers for the eight-lane demultiplexing register
//   bank (dmux_bank8) and its write-enable decoder (dmux8way).
//   Contents:
//     DATA_WIDTH   - default lane data width in bits
//     LANE_COUNT   - number of lanes (fixed at 8 in this revision)
//     SEL_WIDTH    - width of a lane index (3 bits addresses 8 lanes)
//     COUNT_WIDTH  - width of the valid-lane count (0..8 needs 4 bits)
//     popcount8()  - number of set bits in an 8-bit vector
package dmux_bank8_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int LANE_COUNT  = 8;
  localparam int SEL_WIDTH   = 3;
  localparam int COUNT_WIDTH = 4;

  // Result width is 4 bits, so a full vector yields 8 with no wrap.
  function automatic logic [COUNT_WIDTH-1:0] popcount8(input logic [LANE_COUNT-1:0] v);
    logic [COUNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      cnt = cnt + {{(COUNT_WIDTH-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dmux_bank8_dmux8way.sv
// dmux8way
//   3-to-8 one-hot demultiplexer used as the lane write-enable decoder.
//   Exactly one output bit is high when i_en is high; all outputs are low
//   otherwise. Every 3-bit select value maps to a lane.
//   Ports:
//     i_en      in   1  - enable (the bank's load strobe)
//     i_sel     in   3  - lane index to enable
//     o_onehot  out  8  - one-hot write enables, bit k for lane k
module dmux8way
  import dmux_bank8_pkg::*;
(
  input  logic                  i_en,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  output logic [LANE_COUNT-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/dmux_bank8.sv
// dmux_bank8
//   Eight-lane register bank fed by a demultiplexer. A load writes the input
//   word into the selected lane and marks it valid; clear flushes all lanes
//   except one being loaded in the same cycle. A registered popcount of the
//   valid bits and a combinational readback mux are provided.
//   Ports:
//     clk          in   1              - clock, rising edge
//     rst_n        in   1              - asynchronous active-low reset
//     in           in   WIDTH          - data word to store
//     sel          in   3              - destination lane for load
//     load         in   1              - write 'in' into lane 'sel'
//     clear        in   1              - synchronous flush of all lanes
//     rd_sel       in   3              - lane index for readback
//     out_bus      out  LANES*WIDTH    - lane k at [k*WIDTH +: WIDTH]
//     lane_valid   out  LANES          - lane k loaded since reset/clear
//     rd_data      out  WIDTH          - lane rd_sel, no added latency
//     valid_count  out  4              - popcount of lane_valid
module dmux_bank8
  import dmux_bank8_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int LANES = LANE_COUNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in,
  input  logic [SEL_WIDTH-1:0]     sel,
  input  logic                     load,
  input  logic                     clear,
  input  logic [SEL_WIDTH-1:0]     rd_sel,
  output logic [LANES*WIDTH-1:0]   out_bus,
  output logic [LANES-1:0]         lane_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [COUNT_WIDTH-1:0]   valid_count
);

  logic [WIDTH-1:0]       r_lane [LANES];
  logic [LANES-1:0]       r_valid;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [LANES-1:0]       w_we;
  logic [LANES-1:0]       w_validNext;

  dmux8way u_dmux8way (
    .i_en     (load),
    .i_sel    (sel),
    .o_onehot (w_we)
  );

  // The write enable is applied after the clear so a load keeps its own lane
  // when both strobes arrive together.
  always_comb begin
    w_validNext = r_valid;
    if (clear) begin
      w_validNext = '0;
    end
    w_validNext = w_validNext | w_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (w_we[k]) begin
          r_lane[k] <= in;
        end else if (clear) begin
          r_lane[k] <= '0;
        end
      end
    end
  end

  // The count is taken from the next-state valid vector so that it lands on
  // the same edge as lane_valid and always matches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_validNext;
      r_count <= popcount8(w_validNext);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bus
    assign out_bus[g*WIDTH +: WIDTH] = r_lane[g];
  end

  // Readback mux reads the registers directly, so a write in progress is
  // not visible until after its capturing edge.
  assign rd_data     = r_lane[rd_sel];
  assign lane_valid  = r_valid;
  assign valid_count = r_count;

endmodule

// File: doc/dmux_bank8.md
DMUX_BANK8 -- requirements
Module: dmux_bank8

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter LANES, default 8: number of output lanes; fixed at 8 for this revision.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port in  input  WIDTH: data word to be demultiplexed.
REQ-006 Port sel  input  3: destination lane index for a load.
REQ-007 Port load  input  1: write `in` into lane `sel` at the next rising edge.
REQ-008 Port clear  input  1: synchronous flush of all lanes.
REQ-009 Port rd_sel  input  3: lane index for readback.
REQ-010 Port out_bus  output  LANES*WIDTH: registered lane contents; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Port lane_valid  output  LANES: bit k is high when lane k holds data loaded since the last reset or clear.
REQ-012 Port rd_data  output  WIDTH: combinational readback of lane rd_sel.
REQ-013 Port valid_count  output  4: number of bits set in lane_valid, range 0..8.

Function
REQ-014 On a rising edge with load=1, lane sel shall capture `in`, and lane_valid[sel] shall be set; all other lanes shall hold their values.
REQ-015 Load latency shall be one cycle: new data shall be visible on out_bus and rd_data after the capturing edge.
REQ-016 On a rising edge with clear=1 and load=0, every lane and every lane_valid bit shall become 0.
REQ-017 On a rising edge with clear=1 and load=1, all lanes except sel shall clear; lane sel shall capture `in` with lane_valid[sel]=1, so load wins on its own lane.
REQ-018 Reloading a lane that is already valid shall overwrite its data; lane_valid shall remain 1 and valid_count shall not change.
REQ-019 rd_data shall equal lane rd_sel of out_bus with no added latency, including in the same cycle as a write to that lane (it returns the pre-edge value).
REQ-020 valid_count shall be registered and shall always equal the popcount of lane_valid; the count shall saturate naturally at 8 with no wrap.
REQ-021 With load=0 and clear=0, all state shall hold indefinitely.
REQ-022 sel and rd_sel shall be fully decoded; every 3-bit value shall be legal, so no X and no unmapped case exists.

Reset
REQ-023 When rst_n is low, all lanes, lane_valid and valid_count shall go to 0 immediately, independent of clk.
REQ-024 An rst_n assertion that coincides with a load edge shall win, and the load shall be discarded.
REQ-025 After rst_n deasserts, the first rising edge shall process load and clear normally.

Structure
REQ-026 A shared package shall hold the WIDTH and LANES defaults, the lane-index width (3), and the count width (4).
REQ-027 The one-hot write-enable decoder (3-to-8 demux gated by load) shall be a sub-module named dmux8way.
REQ-028 Lane storage shall be 8 WIDTH-bit registers each enabled by one dmux8way output; readback shall be an 8-way mux.

Verification
REQ-029 Reset, then load in=16'h1234, sel=3 for one cycle -> out_bus lane 3 = 16'h1234, other lanes 0, lane_valid=8'h08, valid_count=1.
REQ-030 Load lanes 0..7 with 16'h0000+k*16'h1111 on consecutive cycles -> lane_valid=8'hFF, valid_count=8; rd_sel=5 gives 16'h5555.
REQ-031 With all lanes valid, assert clear=1, load=1, sel=2, in=16'hBEEF -> only lane 2 = 16'hBEEF, lane_valid=8'h04, valid_count=1.
REQ-032 Reload lane 3 with 16'hAAAA after 16'h1234 -> lane 3 = 16'hAAAA, valid_count unchanged; rd_sel=3 shows 16'h1234 until the edge and 16'hAAAA after it.
REQ-033 Pull rst_n low mid-cycle with lanes loaded -> all outputs 0 before the next clk edge; a load presented during reset is not captured.
